fp_merge: RTL and testbench



---
 rtl/float_pkg.sv | 25 ++
 rtl/fp_key_cmp.sv | 12 +
 rtl/fp_merge.sv | 102 ++++++++++
 tb/tb_fp_merge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared float type, merge FSM state encoding and the unsigned order key
// used to compare floats as plain integers.
package float_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  typedef enum logic [1:0] {
    MERGE,
    DRAIN_A,
    DRAIN_B
  } fp_merge_state_t;

  // Negative values invert fully so larger magnitudes sort lower; positives
  // flip the sign bit so they land above all negatives (-0 sorts below +0).
  function automatic logic [31:0] fp_order_key(float x);
    logic [31:0] bits;
    bits = x;
    return x.sign ? ~bits : (bits ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp_key_cmp.sv
// Combinational order comparator: a_le_b when key(a) <= key(b).
module fp_key_cmp
  import float_pkg::*;
(
  input  float a,
  input  float b,
  output logic a_le_b
);

  assign a_le_b = fp_order_key(a) <= fp_order_key(b);

endmodule

// File: rtl/fp_merge.sv
// Two-way streaming merge of ascending float jobs into one ascending job.
// Optional input order checker enabled by FP_MERGE_ORDER_CHECK_EN.
module fp_merge
  import float_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  float a_data,
  input  logic a_last,
  input  logic a_valid,
  output logic a_ready,
  input  float b_data,
  input  logic b_last,
  input  logic b_valid,
  output logic b_ready,
  output float out_data,
  output logic out_last,
  output logic out_valid,
  input  logic out_ready,
  output logic order_err
);

  fp_merge_state_t state;
  logic load, sel_a, a_fire, b_fire, both;

  fp_key_cmp u_sel (.a(a_data), .b(b_data), .a_le_b(sel_a));

  assign load   = !out_valid || out_ready;
  assign both   = a_valid && b_valid;
  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      MERGE: begin
        a_ready = load && both && sel_a;
        b_ready = load && both && !sel_a;
      end
      DRAIN_A: a_ready = load && a_valid;
      DRAIN_B: b_ready = load && b_valid;
      default: ;
    endcase
  end

  // A last flag closes the merged job only when popped from a drain state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MERGE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (a_fire) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_last  <= (state == DRAIN_A) && a_last;
      if (a_last) state <= (state == MERGE) ? DRAIN_B : MERGE;
    end else if (b_fire) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_last  <= (state == DRAIN_B) && b_last;
      if (b_last) state <= (state == MERGE) ? DRAIN_A : MERGE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef FP_MERGE_ORDER_CHECK_EN
  float prev_a, prev_b;
  logic prev_a_vld, prev_b_vld, a_ok, b_ok;

  fp_key_cmp u_chk_a (.a(prev_a), .b(a_data), .a_le_b(a_ok));
  fp_key_cmp u_chk_b (.a(prev_b), .b(b_data), .a_le_b(b_ok));

  // prev_*_vld drops after a stream's last pop, so each job starts unchecked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a     <= '0;
      prev_b     <= '0;
      prev_a_vld <= 1'b0;
      prev_b_vld <= 1'b0;
      order_err  <= 1'b0;
    end else begin
      if (a_fire) begin
        prev_a     <= a_data;
        prev_a_vld <= !a_last;
        if (prev_a_vld && !a_ok) order_err <= 1'b1;
      end
      if (b_fire) begin
        prev_b     <= b_data;
        prev_b_vld <= !b_last;
        if (prev_b_vld && !b_ok) order_err <= 1'b1;
      end
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_merge.sv
// Bench for fp_merge: directed cases plus random jobs against a stable-sort
// reference (A before B on equal keys).
module tb_fp_merge;
  import float_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  float a_data, b_data, out_data;
  logic a_last, a_valid, a_ready;
  logic b_last, b_valid, b_ready;
  logic out_last, out_valid, out_ready, order_err;
  logic [31:0] od;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ja[$];
  logic [31:0] jb[$];
  logic [31:0] jexp[$];

`ifdef FP_MERGE_ORDER_CHECK_EN
  localparam logic ORDER_EXP = 1'b1;
`else
  localparam logic ORDER_EXP = 1'b0;
`endif

  fp_merge dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .order_err(order_err)
  );

  assign od = out_data;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkey(logic [31:0] v);
    if (v[31]) return ~v;
    return v + 32'h8000_0000;
  endfunction

  // Stable insertion sort by order key.
  task automatic sort_q(inout logic [31:0] q[$]);
    for (int i = 1; i < q.size(); i++) begin
      logic [31:0] t;
      int j;
      t = q[i];
      j = i - 1;
      while (j >= 0 && mkey(q[j]) > mkey(t)) begin
        q[j+1] = q[j];
        j--;
      end
      q[j+1] = t;
    end
  endtask

  task automatic model_merge();
    jexp = {};
    foreach (ja[i]) jexp.push_back(ja[i]);
    foreach (jb[i]) jexp.push_back(jb[i]);
    sort_q(jexp);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_job(input int ready_mode, input bit rand_valid, input int stop_after);
    int ia = 0, ib = 0, no = 0, cyc = 0, rp = 0, total;
    bit fa = 0, fb = 0, stall = 0;
    logic [31:0] held = '0;
    logic [3:0] pat = 4'b1001;
    total = (stop_after > 0) ? stop_after : jexp.size();
    while (no < total && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fa) ia++;
      if (fb) ib++;
      if (fa || !a_valid) begin
        if (ia < ja.size() && (!rand_valid || $urandom_range(3) != 0)) begin
          a_valid = 1'b1; a_data = ja[ia]; a_last = (ia == ja.size() - 1);
        end else begin
          a_valid = 1'b0; a_data = $urandom; a_last = 1'b0;
        end
      end
      if (fb || !b_valid) begin
        if (ib < jb.size() && (!rand_valid || $urandom_range(3) != 0)) begin
          b_valid = 1'b1; b_data = jb[ib]; b_last = (ib == jb.size() - 1);
        end else begin
          b_valid = 1'b0; b_data = $urandom; b_last = 1'b0;
        end
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = pat[3 - (rp % 4)]; rp++; end
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", od, held);
      end
      #1;
      if (out_valid && !out_ready)
        chk("bp_readies", {30'd0, a_ready, b_ready}, 32'd0);
      if (ready_mode == 0 && !rand_valid && cyc >= 2)
        chk("throughput", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        chk("out_data", od, jexp[no]);
        chk("out_last", 32'(out_last), 32'(no == jexp.size() - 1));
        no++;
      end
      stall = out_valid && !out_ready;
      held  = od;
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
    end
    if (cyc >= 2000) chk("timeout", 32'(no), 32'(total));
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic case1();
    ja = {32'h3F80_0000, 32'h4040_0000, 32'h40A0_0000};
    jb = {32'h4000_0000, 32'h4080_0000};
    jexp = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
  endtask

  task automatic case2();
    ja = {32'hC0A0_0000, 32'hC080_0000};
    jb = {32'h8000_0000, 32'h4060_0000, 32'h40E6_6666};
    jexp = {32'hC0A0_0000, 32'hC080_0000, 32'h8000_0000, 32'h4060_0000, 32'h40E6_6666};
  endtask

  task automatic rand_job();
    logic [31:0] pool[6];
    int na, nb;
    pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000; pool[2] = 32'h4000_0000;
    pool[3] = 32'hC000_0000; pool[4] = 32'h3F80_0000; pool[5] = 32'h7FC0_0000;
    na = $urandom_range(8, 1);
    nb = $urandom_range(8, 1);
    ja = {}; jb = {};
    for (int i = 0; i < na; i++) ja.push_back($urandom_range(2) == 0 ? pool[$urandom_range(5)] : $urandom);
    for (int i = 0; i < nb; i++) jb.push_back($urandom_range(2) == 0 ? pool[$urandom_range(5)] : $urandom);
    sort_q(ja);
    sort_q(jb);
    model_merge();
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", od, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_readies", {30'd0, a_ready, b_ready}, 32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    case1(); run_job(0, 0, 0);
    case2(); run_job(0, 0, 0);
    ja = {32'h4000_0000}; jb = {32'h4000_0000}; model_merge();
    chk("model_tie", jexp.size() == 2 ? 32'd1 : 32'd0, 32'd1);
    run_job(0, 0, 0);
    ja = {32'h0000_0000}; jb = {32'h8000_0000};
    jexp = {32'h8000_0000, 32'h0000_0000};
    run_job(0, 0, 0);
    case1(); run_job(1, 0, 0);
    chk("order_err_clean", 32'(order_err), 32'd0);

    // Abort case 1 after two outputs, then case 2 must come out intact.
    case1(); run_job(0, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", od, 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_readies", {30'd0, a_ready, b_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    case2(); run_job(0, 0, 0);

    for (int j = 0; j < 30; j++) begin
      rand_job();
      run_job(j % 3, (j % 3) != 0, 0);
    end
    chk("order_err_rand", 32'(order_err), 32'd0);

    ja = {32'h4040_0000, 32'h3F80_0000}; jb = {32'h4000_0000};
    jexp = {32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
    run_job(0, 0, 0);
    @(negedge clk);
    chk("order_err_set", 32'(order_err), 32'(ORDER_EXP));
    repeat (3) @(negedge clk);
    chk("order_err_sticky", 32'(order_err), 32'(ORDER_EXP));
    rst_n = 1'b0;
    #1;
    chk("order_err_rst", 32'(order_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
